video_timing: RTL and testbench



---
 rtl/video_timing_pkg.sv | 44 ++++
 rtl/video_timing_sync_delay.sv | 41 ++++
 rtl/video_timing.sv | 157 +++++++++++++++
 tb/tb_video_timing.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared raster constants for the video timing generator.
//   - Default 640x480@60 VGA timing (pixel clock 25.175 MHz nominal).
//   - Line/frame totals, counter width, game-area geometry.
//   - Bundle type for the {hsync, vsync, visible} signals and its idle value.
package video_timing_pkg;

  localparam int unsigned H_VISIBLE_DEF  = 640;
  localparam int unsigned H_FRONT_DEF    = 16;
  localparam int unsigned H_SYNC_DEF     = 96;
  localparam int unsigned H_BACK_DEF     = 48;
  localparam int unsigned V_VISIBLE_DEF  = 480;
  localparam int unsigned V_FRONT_DEF    = 10;
  localparam int unsigned V_SYNC_DEF     = 2;
  localparam int unsigned V_BACK_DEF     = 33;
  localparam int unsigned H_OFFSET_DEF   = 64;
  localparam int unsigned SYNC_DELAY_DEF = 2;

  localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Game area is 256x240, shown 2x-doubled as a 512x480 window.
  localparam int unsigned GAME_W = 256;
  localparam int unsigned GAME_H = 240;
  localparam int unsigned WIN_W  = 2 * GAME_W;

  // Wide enough for both h (0..799) and v (0..524).
  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic visible;
  } sync_t;

  // Idle state of the sync bundle: syncs deasserted (high), not visible.
  localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, visible: 1'b0};

  // Half-open interval test: lo <= val < hi.
  function automatic logic in_span(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/video_timing_sync_delay.sv
// sync_delay: parameterised N-stage shift register with a per-bit reset value.
//   i_clk    - clock
//   i_rst_n  - synchronous active-low reset; every stage loads ResetVal
//   i_d      - input word
//   o_q      - i_d delayed by Depth clocks (Depth = 0 is a wire)
module sync_delay #(
  parameter int unsigned Width    = 1,
  parameter int unsigned Depth    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  if (Depth == 0) begin : g_bypass
    assign o_q = i_d;

    logic w_unused_ctrl;
    assign w_unused_ctrl = i_clk ^ i_rst_n;
  end else begin : g_shift
    logic [Width-1:0] r_stage [Depth];

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          r_stage[i] <= ResetVal;
        end
      end else begin
        r_stage[0] <= i_d;
        for (int unsigned i = 1; i < Depth; i++) begin
          r_stage[i] <= r_stage[i-1];
        end
      end
    end

    assign o_q = r_stage[Depth-1];
  end

endmodule

// File: rtl/video_timing.sv
// video_timing: raster timing generator for the GPU.
//   Free-running h/v counters produce 640x480@60 timing; the 256x240 game area
//   is mapped 2x-doubled onto a 512x480 window starting at column H_OFFSET.
// Ports:
//   gpu_clk         - pixel clock
//   rst_n           - synchronous active-low reset
//   display_x_o     - game-area column 0..255 (0 outside the window)
//   display_y_o     - game-area row 0..239 (0 outside the visible lines)
//   game_area_o     - inside the 512x480 window, undelayed
//   visible_o       - inside the 640x480 active region, delayed SYNC_DELAY clocks
//   hsync_n_o       - active-low hsync, delayed SYNC_DELAY clocks
//   vsync_n_o       - active-low vsync, delayed SYNC_DELAY clocks
//   vblank_start_o  - one-clock pulse at h=0, v=V_VISIBLE
//   frame_o         - toggles together with vblank_start_o
module video_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT    = H_FRONT_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BACK     = H_BACK_DEF,
  parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT    = V_FRONT_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BACK     = V_BACK_DEF,
  parameter int unsigned H_OFFSET   = H_OFFSET_DEF,
  // Matches the downstream pixel pipeline depth; 0..7.
  parameter int unsigned SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic       gpu_clk,
  input  logic       rst_n,
  output logic [7:0] display_x_o,
  output logic [7:0] display_y_o,
  output logic       game_area_o,
  output logic       visible_o,
  output logic       hsync_n_o,
  output logic       vsync_n_o,
  output logic       vblank_start_o,
  output logic       frame_o
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t HLast    = cnt_t'(HTotal - 1);
  localparam cnt_t VLast    = cnt_t'(VTotal - 1);
  localparam cnt_t HVis     = cnt_t'(H_VISIBLE);
  localparam cnt_t VVis     = cnt_t'(V_VISIBLE);
  localparam cnt_t HSyncLo  = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HSyncHi  = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam cnt_t VSyncLo  = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VSyncHi  = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam cnt_t WinLo    = cnt_t'(H_OFFSET);
  localparam cnt_t WinHi    = cnt_t'(H_OFFSET + WIN_W);

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  cnt_t r_h;
  cnt_t r_v;
  cnt_t w_h_next;
  cnt_t w_v_next;
  logic w_line_end;

  always_comb begin
    w_line_end = (r_h == HLast);
    w_h_next   = w_line_end ? '0 : r_h + cnt_t'(1);
    w_v_next   = r_v;
    if (w_line_end) begin
      // Line and frame wrap share the same edge.
      w_v_next = (r_v == VLast) ? '0 : r_v + cnt_t'(1);
    end
  end

  always_ff @(posedge gpu_clk) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_next;
      r_v <= w_v_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Vertical blank pulse and frame toggle
  // ---------------------------------------------------------------------------
  // Decoded from the next counter state so the pulse is registered yet lines up
  // exactly with h=0, v=V_VISIBLE.
  logic w_vblank_next;
  logic r_vblank_start;
  logic r_frame;

  assign w_vblank_next = (w_h_next == '0) && (w_v_next == VVis);

  always_ff @(posedge gpu_clk) begin
    if (!rst_n) begin
      r_vblank_start <= 1'b0;
      r_frame        <= 1'b0;
    end else begin
      r_vblank_start <= w_vblank_next;
      r_frame        <= r_frame ^ w_vblank_next;
    end
  end

  assign vblank_start_o = r_vblank_start;
  assign frame_o        = r_frame;

  // ---------------------------------------------------------------------------
  // Game-area mapping (zero latency from the counters)
  // ---------------------------------------------------------------------------
  logic w_v_vis;
  logic w_game_area;
  cnt_t w_x_off;

  assign w_v_vis     = (r_v < VVis);
  assign w_game_area = in_span(r_h, WinLo, WinHi) && w_v_vis;
  // 10-bit subtraction; bit 0 is the doubling phase, bit 9 only matters out of
  // window, where the result is forced to 0.
  assign w_x_off     = r_h - WinLo;

  assign game_area_o = w_game_area;
  assign display_x_o = w_game_area ? w_x_off[8:1] : 8'd0;
  assign display_y_o = w_v_vis ? r_v[8:1] : 8'd0;

  logic w_unused;
  assign w_unused = ^{w_x_off[9], w_x_off[0], r_v[9], r_v[0]};

  // ---------------------------------------------------------------------------
  // Sync / visible generation and pipeline alignment
  // ---------------------------------------------------------------------------
  sync_t w_sync_raw;
  sync_t w_sync_dly;

  always_comb begin
    w_sync_raw         = SYNC_IDLE;
    w_sync_raw.hsync_n = !in_span(r_h, HSyncLo, HSyncHi);
    w_sync_raw.vsync_n = !in_span(r_v, VSyncLo, VSyncHi);
    w_sync_raw.visible = (r_h < HVis) && w_v_vis;
  end

  sync_delay #(
    .Width    (3),
    .Depth    (SYNC_DELAY),
    .ResetVal (SYNC_IDLE)
  ) u_sync_delay (
    .i_clk   (gpu_clk),
    .i_rst_n (rst_n),
    .i_d     (w_sync_raw),
    .o_q     (w_sync_dly)
  );

  assign hsync_n_o = w_sync_dly.hsync_n;
  assign vsync_n_o = w_sync_dly.vsync_n;
  assign visible_o = w_sync_dly.visible;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing. Horizontal timing is the default 800-clock VGA line;
// the vertical parameters are shrunk to a 24-line frame so several frames fit
// in a short run. Expected outputs are derived from the elapsed clock count
// since reset release using plain division/modulo.
module tb_video_timing;

  localparam int unsigned HT  = 800;
  localparam int unsigned HO  = 64;
  localparam int unsigned VV  = 16;
  localparam int unsigned VF  = 2;
  localparam int unsigned VS  = 2;
  localparam int unsigned VB  = 4;
  localparam int unsigned VT  = VV + VF + VS + VB;
  localparam int unsigned FL  = HT * VT;
  localparam int unsigned P   = VV * HT;
  localparam int unsigned SD  = 2;

  logic       gpu_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] display_x_o;
  logic [7:0] display_y_o;
  logic       game_area_o;
  logic       visible_o;
  logic       hsync_n_o;
  logic       vsync_n_o;
  logic       vblank_start_o;
  logic       frame_o;

  video_timing #(
    .V_VISIBLE  (VV),
    .V_FRONT    (VF),
    .V_SYNC     (VS),
    .V_BACK     (VB),
    .SYNC_DELAY (SD)
  ) dut (
    .gpu_clk        (gpu_clk),
    .rst_n          (rst_n),
    .display_x_o    (display_x_o),
    .display_y_o    (display_y_o),
    .game_area_o    (game_area_o),
    .visible_o      (visible_o),
    .hsync_n_o      (hsync_n_o),
    .vsync_n_o      (vsync_n_o),
    .vblank_start_o (vblank_start_o),
    .frame_o        (frame_o)
  );

  always #5 gpu_clk = ~gpu_clk;

  int unsigned t;        // clocks since the last reset edge
  int          n_tests;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d: got %0d expected %0d", tag, t, got, exp);
    end
  endtask

  // Undelayed sync/visible values at clock index tt.
  task automatic raw_at(input int unsigned tt, output logic hs, output logic vs,
                        output logic vis);
    int unsigned hh;
    int unsigned vv;
    hh  = tt % HT;
    vv  = (tt / HT) % VT;
    hs  = !(hh >= 656 && hh < 752);
    vs  = !(vv >= VV + VF && vv < VV + VF + VS);
    vis = (hh < 640) && (vv < VV);
  endtask

  task automatic check_outputs();
    int unsigned h;
    int unsigned v;
    logic        ga;
    logic        hs;
    logic        vs;
    logic        vis;
    int unsigned pulses;
    h  = t % HT;
    v  = (t / HT) % VT;
    ga = (h >= HO) && (h < HO + 512) && (v < VV);
    chk("game_area", 32'(game_area_o), 32'(ga));
    chk("display_x", 32'(display_x_o), ga ? (h - HO) / 2 : 0);
    chk("display_y", 32'(display_y_o), (v < VV) ? v / 2 : 0);
    if (t >= SD) begin
      raw_at(t - SD, hs, vs, vis);
    end else begin
      hs  = 1'b1;
      vs  = 1'b1;
      vis = 1'b0;
    end
    chk("hsync_n", 32'(hsync_n_o), 32'(hs));
    chk("vsync_n", 32'(vsync_n_o), 32'(vs));
    chk("visible", 32'(visible_o), 32'(vis));
    chk("vblank_start", 32'(vblank_start_o), 32'(h == 0 && v == VV));
    pulses = (t >= P) ? (t - P) / FL + 1 : 0;
    chk("frame", 32'(frame_o), pulses % 2);
  endtask

  task automatic tick(input logic r);
    rst_n = r;
    @(posedge gpu_clk);
    if (!r) t = 0;
    else    t++;
    @(negedge gpu_clk);
    check_outputs();
  endtask

  initial begin
    int unsigned cnt;
    int unsigned first_h;
    int unsigned vs_lo;
    int unsigned n_pulse;
    int unsigned n_toggle;
    logic        prev_frame;
    logic        found;

    n_tests = 0;
    n_fail  = 0;
    t       = 0;

    // Reset held for a few clocks: h=0,v=0 state with an idle delay line.
    repeat (3) tick(1'b0);
    chk("rst_hsync", 32'(hsync_n_o), 32'd1);
    chk("rst_visible", 32'(visible_o), 32'd0);

    // Window opens at h=64.
    repeat (64) tick(1'b1);
    chk("ga_at_64", 32'(game_area_o), 32'd1);
    chk("dx_at_64", 32'(display_x_o), 32'd0);

    // Pixel doubling: 0,0,1,1,...,255,255.
    for (int k = 0; k < 512; k++) begin
      chk("dx_seq", 32'(display_x_o), 32'(k / 2));
      tick(1'b1);
    end
    chk("ga_at_576", 32'(game_area_o), 32'd0);
    chk("dx_at_576", 32'(display_x_o), 32'd0);

    // One full line of hsync.
    cnt     = 0;
    first_h = 0;
    repeat (HT) begin
      tick(1'b1);
      if (!hsync_n_o) begin
        if (cnt == 0) first_h = t % HT;
        cnt++;
      end
    end
    chk("hsync_low_len", cnt, 96);
    chk("hsync_first_h", first_h, 658);

    // One full frame from an arbitrary phase.
    vs_lo      = 0;
    n_pulse    = 0;
    n_toggle   = 0;
    prev_frame = frame_o;
    repeat (FL) begin
      tick(1'b1);
      if (!vsync_n_o) vs_lo++;
      if (vblank_start_o) n_pulse++;
      if (frame_o != prev_frame) n_toggle++;
      prev_frame = frame_o;
      if (t % HT == 0 && ((t / HT) % VT == VV - 1 || (t / HT) % VT == VV - 2))
        chk("dy_last_rows", 32'(display_y_o), VV / 2 - 1);
      if (t % HT == 0 && (t / HT) % VT == VV)
        chk("dy_blank", 32'(display_y_o), 32'd0);
    end
    chk("vsync_low_len", vs_lo, VS * HT);
    chk("vblank_per_frame", n_pulse, 1);
    chk("frame_toggles", n_toggle, 1);

    // Random run lengths with short random resets in between.
    repeat (4) begin
      repeat ($urandom_range(3000, 50)) tick(1'b1);
      repeat ($urandom_range(3, 1)) tick(1'b0);
    end

    // Advance to h=400, v=12 and reset there for exactly one clock.
    cnt = 0;
    while (!(t % HT == 400 && (t / HT) % VT == 12) && cnt < 2 * FL) begin
      tick(1'b1);
      cnt++;
    end
    chk("reach_mid_frame", 32'(t % HT == 400 && (t / HT) % VT == 12), 32'd1);
    tick(1'b0);
    chk("mid_rst_hsync", 32'(hsync_n_o), 32'd1);
    chk("mid_rst_vsync", 32'(vsync_n_o), 32'd1);
    chk("mid_rst_visible", 32'(visible_o), 32'd0);

    // Next vblank pulse must come a full visible region after release.
    cnt   = 0;
    found = 1'b0;
    while (!found && cnt < 2 * P) begin
      tick(1'b1);
      cnt++;
      if (vblank_start_o) found = 1'b1;
    end
    chk("vblank_after_reset", cnt, P);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
